// File: rtl/fpu_rr_arbiter.sv
// rtl/fpu_rr_arbiter.sv - round-robin arbiter sharing one fixed-latency FP32 unit
// Grants one requester per cycle, registers its operands onto the FPU and routes results back by tag.
module fpu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 3,
  parameter int OPW     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*OPW-1:0] req_op,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   fpu_valid,
  output logic [OPW-1:0]         fpu_op,
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  input  logic [31:0]            fpu_result,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   busy
);

  localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [TW-1:0]      ptr_q, ptr_d;
  logic [TW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               hs;

  logic               fpu_valid_q;
  logic [OPW-1:0]     fpu_op_q;
  logic [31:0]        fpu_a_q, fpu_b_q;
  logic [TW-1:0]      issue_tag_q;

  logic [FPU_LAT-1:0] stg_vld_q;
  logic [TW-1:0]      stg_tag_q [FPU_LAT];

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [31:0]        rsp_data_q;

  // Scan from the pointer upward with modulo wrap; first valid requester wins.
  always_comb begin
    logic [TW:0]   sum;
    logic [TW-1:0] idx;
    logic          found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (TW+1)'(k);
      if (sum >= (TW+1)'(NUM_REQ)) sum = sum - (TW+1)'(NUM_REQ);
      idx = sum[TW-1:0];
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  assign req_ready = rst_n ? grant : '0;
  assign hs        = |req_ready;
  assign ptr_d     = (grant_idx == TW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      fpu_valid_q <= 1'b0;
      fpu_op_q    <= '0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      issue_tag_q <= '0;
      stg_vld_q   <= '0;
      for (int i = 0; i < FPU_LAT; i++) stg_tag_q[i] <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      fpu_valid_q <= hs;
      if (hs) begin
        fpu_op_q    <= req_op[grant_idx*OPW +: OPW];
        fpu_a_q     <= req_a[grant_idx*32 +: 32];
        fpu_b_q     <= req_b[grant_idx*32 +: 32];
        issue_tag_q <= grant_idx;
        ptr_q       <= ptr_d;
      end
      // Owner tags travel alongside the FPU pipeline so the result lands on the right requester.
      stg_vld_q[0] <= fpu_valid_q;
      stg_tag_q[0] <= issue_tag_q;
      for (int i = 1; i < FPU_LAT; i++) begin
        stg_vld_q[i] <= stg_vld_q[i-1];
        stg_tag_q[i] <= stg_tag_q[i-1];
      end
      rsp_valid_q <= '0;
      if (stg_vld_q[FPU_LAT-1]) begin
        rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << stg_tag_q[FPU_LAT-1];
        rsp_data_q  <= fpu_result;
      end
    end
  end

  assign fpu_valid = fpu_valid_q;
  assign fpu_op    = fpu_op_q;
  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = fpu_valid_q | (|stg_vld_q);

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// tb/tb_fpu_rr_arbiter.sv - directed bench for fpu_rr_arbiter with a 3-cycle FP32 add model
module tb_fpu_rr_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int OPW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*OPW-1:0] req_op;
  logic [N*32-1:0]  req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           fpu_valid;
  logic [OPW-1:0] fpu_op;
  logic [31:0]    fpu_a, fpu_b, fpu_result;
  logic [N-1:0]   rsp_valid;
  logic [31:0]    rsp_data;
  logic           busy;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  typedef struct {
    logic [N-1:0] v;
    logic [31:0]  d;
    int           c;
  } rsp_t;
  rsp_t rq[$];

  fpu_rr_arbiter #(.NUM_REQ(N), .FPU_LAT(LAT), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .fpu_valid(fpu_valid),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result(fpu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Float32 <-> real for normal numbers and zero; enough for exact small sums.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else begin
      e = {3'b000, f[30:23]} + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_model(input logic [OPW-1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == '0) return r2f(f2r(a) + f2r(b));
    return a ^ b;
  endfunction

  logic [31:0] p0, p1, p2;
  always @(posedge clk) begin
    p0  <= fpu_valid ? fpu_model(fpu_op, fpu_a, fpu_b) : 32'hDEAD_BEEF;
    p1  <= p0;
    p2  <= p1;
    cyc <= cyc + 1;
  end
  assign fpu_result = p2;

  always @(negedge clk) begin
    if (rsp_valid != '0) rq.push_back('{v: rsp_valid, d: rsp_data, c: cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [OPW-1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[i*OPW +: OPW] = op;
    req_a[i*32 +: 32]    = a;
    req_b[i*32 +: 32]    = b;
  endtask

  logic [31:0] fair_exp [4] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
  logic [31:0] b2b_a    [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
  logic [31:0] b2b_exp  [5] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
  int hs0;

  initial begin
    rst_n = 1'b0; req_valid = '1; req_op = '0; req_a = '0; req_b = '0;

    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_ready", req_ready, 4'b0000);
      check("rst_fpu_valid", fpu_valid, 1'b0);
      check("rst_rsp_valid", rsp_valid, 4'b0000);
      check("rst_busy", busy, 1'b0);
    end
    check("rst_fpu_a", fpu_a, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);

    rst_n = 1'b1; req_valid = '0;
    step();

    // Single op from requester 2.
    set_req(2, 2'd0, 32'h3F80_0000, 32'h4000_0000);
    req_valid = 4'b0100;
    #1 check("single_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    check("single_fpu_valid", fpu_valid, 1'b1);
    check("single_fpu_a", fpu_a, 32'h3F80_0000);
    check("single_fpu_op", fpu_op, 2'd0);
    check("single_busy", busy, 1'b1);
    for (int j = 1; j <= 3; j++) begin
      step();
      check("single_early", rsp_valid, 4'b0000);
    end
    step();
    check("single_rsp_valid", rsp_valid, 4'b0100);
    check("single_rsp_data", rsp_data, 32'h4040_0000);
    step();
    check("single_rsp_off", rsp_valid, 4'b0000);
    check("single_idle", busy, 1'b0);

    // Pointer is 3: skip upward with wrap, then grant 3 with pointer 1.
    req_valid = 4'b0011;
    #1 check("skip_grant0", req_ready, 4'b0001);
    step();
    check("skip_grant1", req_ready, 4'b0010);
    req_valid = 4'b1000;
    #1 check("ptr1_grant3", req_ready, 4'b1000);
    step();
    req_valid = 4'b0011;
    #1 check("wrap_ptr0", req_ready, 4'b0001);
    req_valid = '0;
    repeat (8) step();

    // Fairness: all four valid for 8 cycles.
    rq.delete();
    for (int i = 0; i < N; i++) set_req(i, 2'd0, b2b_a[i], 32'h3F80_0000);
    req_valid = '1;
    hs0 = cyc + 1;
    for (int k = 0; k < 8; k++) begin
      #1 check("fair_grant", req_ready, 4'b0001 << (k % 4));
      step();
    end
    req_valid = '0;
    repeat (8) step();
    check("fair_count", rq.size(), 8);
    for (int k = 0; k < rq.size() && k < 8; k++) begin
      check("fair_rsp_v", rq[k].v, 4'b0001 << (k % 4));
      check("fair_rsp_d", rq[k].d, fair_exp[k % 4]);
      check("fair_rsp_cyc", rq[k].c, hs0 + 4 + k);
    end

    // Back-to-back requester 1.
    rq.delete();
    req_valid = 4'b0010;
    hs0 = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      set_req(1, 2'd0, b2b_a[k], 32'h3F80_0000);
      #1 check("b2b_ready", req_ready, 4'b0010);
      step();
      check("b2b_fpu_valid", fpu_valid, 1'b1);
      check("b2b_fpu_a", fpu_a, b2b_a[k]);
    end
    req_valid = '0;
    repeat (8) step();
    check("b2b_count", rq.size(), 5);
    for (int k = 0; k < rq.size() && k < 5; k++) begin
      check("b2b_rsp_v", rq[k].v, 4'b0010);
      check("b2b_rsp_d", rq[k].d, b2b_exp[k]);
      check("b2b_rsp_cyc", rq[k].c, hs0 + 4 + k);
    end

    // Opcode passthrough on requester 3 (pointer is 2).
    rq.delete();
    set_req(3, 2'd3, 32'h1234_5678, 32'h0F0F_0F0F);
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    check("op_fpu_op", fpu_op, 2'd3);
    check("op_fpu_b", fpu_b, 32'h0F0F_0F0F);
    repeat (6) step();
    check("op_count", rq.size(), 1);
    if (rq.size() > 0) begin
      check("op_rsp_v", rq[0].v, 4'b1000);
      check("op_rsp_d", rq[0].d, 32'h1D3B_5977);
    end

    // Reset while three ops are in flight.
    rq.delete();
    for (int i = 0; i < 3; i++) set_req(i, 2'd0, 32'h3F80_0000, 32'h3F80_0000);
    req_valid = 4'b0111;
    repeat (3) step();
    req_valid = '0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_busy", busy, 1'b0);
    check("mid_fpu_valid", fpu_valid, 1'b0);
    repeat (10) step();
    check("mid_no_rsp", rq.size(), 0);
    req_valid = '1;
    #1 check("mid_ptr0", req_ready, 4'b0001);
    req_valid = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
